// File: rtl/serial_frame_pkg.sv
// Shared definitions for both ends of the 1011-preamble serial link.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam logic [3:0]  PREAMBLE = 4'b1011;
    localparam int unsigned PRE_LEN  = 4;

endpackage

// File: rtl/frame_bit_counter.sv
// Bit-position counter within a frame; co flags the terminal position.
module frame_bit_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_cnt,
    input  logic             inc_cnt,
    output logic [WIDTH-1:0] count,
    output logic             co
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (rst_cnt) begin
            count <= '0;
        end else if (inc_cnt) begin
            count <= count + WIDTH'(1);
        end
    end

    assign co = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: 1011 preamble, DATA_W payload bits, one low gap cycle.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              ser_out,
    output logic              done
);

    localparam int unsigned FRAME_W = DATA_W + PRE_LEN;
    localparam int unsigned CNT_W   = $clog2(DATA_W + PRE_LEN);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PRE  = PRE;
    localparam logic [1:0] S_DATA = DATA;
    localparam logic [1:0] S_GAP  = GAP;

    logic [1:0]         state, state_nxt;
    logic [FRAME_W-1:0] sr, sr_nxt;
    logic [DATA_W-1:0]  payload_ord;
    logic [CNT_W-1:0]   count;
    logic               rst_cnt, inc_cnt, co;

    // Terminal count lands on the last payload bit of the frame.
    frame_bit_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (FRAME_W - 1)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .rst_cnt (rst_cnt),
        .inc_cnt (inc_cnt),
        .count   (count),
        .co      (co)
    );

    // Payload reordered so the shift register always shifts out of its MSB.
    always_comb begin
        payload_ord = data_in;
        if (LSB_FIRST != 0) begin
            for (int i = 0; i < int'(DATA_W); i++) begin
                payload_ord[i] = data_in[DATA_W-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        rst_cnt   = 1'b0;
        inc_cnt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PRE;
                    sr_nxt    = {PREAMBLE, payload_ord};
                    rst_cnt   = 1'b1;
                end
            end
            S_PRE, S_DATA: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    sr_nxt    = '0;
                    rst_cnt   = 1'b1;
                end else begin
                    sr_nxt  = {sr[FRAME_W-2:0], 1'b0};
                    inc_cnt = 1'b1;
                    if (state == S_PRE && count == CNT_W'(PRE_LEN - 1)) begin
                        state_nxt = S_DATA;
                    end else if (state == S_DATA && co) begin
                        state_nxt = S_GAP;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sr_nxt    = '0;
                rst_cnt   = 1'b1;
            end
        endcase
    end

    // Outputs registered from next-state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ser_out <= 1'b0;
        end else begin
            ready   <= (state_nxt == S_IDLE);
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_GAP);
            ser_out <= ((state_nxt == S_PRE) || (state_nxt == S_DATA)) && sr_nxt[FRAME_W-1];
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench: MSB-first and LSB-first instances against a frame-queue model.
module tb_serial_frame_tx;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready, busy, ser_out, done;
    logic          ready_l, busy_l, ser_out_l, done_l;

    serial_frame_tx #(.DATA_W(DW), .LSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .abort(abort),
        .ready(ready), .busy(busy), .ser_out(ser_out), .done(done)
    );

    serial_frame_tx #(.DATA_W(DW), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .abort(abort),
        .ready(ready_l), .busy(busy_l), .ser_out(ser_out_l), .done(done_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ser_m;
        logic ser_l;
        logic done;
    } exp_t;

    exp_t   q[$];
    logic   line[$];
    logic   cur_idle = 1'b1;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, model the edge, check #1 after posedge.
    task automatic step(input logic s, input logic [DW-1:0] d, input logic a);
        logic [3:0] pre;
        exp_t       e;
        pre     = 4'b1011;
        start   = s;
        data_in = d;
        abort   = a;
        if (cur_idle && s) begin
            for (int i = 0; i < 4; i++) q.push_back({pre[3-i], pre[3-i], 1'b0});
            for (int i = 0; i < int'(DW); i++) q.push_back({d[DW-1-i], d[i], 1'b0});
            q.push_back({1'b0, 1'b0, 1'b1});
        end else if (!cur_idle && a) begin
            q.delete();
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cur_idle = 1'b0;
        end else begin
            e = '0;
            cur_idle = 1'b1;
        end
        line.push_back(ser_out);
        chk("ser_out",   ser_out,   e.ser_m);
        chk("ser_out_l", ser_out_l, e.ser_l);
        chk("done",      done,      e.done);
        chk("done_l",    done_l,    e.done);
        chk("ready",     ready,     cur_idle);
        chk("busy",      busy,      ~cur_idle);
        chk("ready_l",   ready_l,   cur_idle);
        chk("busy_l",    busy_l,    ~cur_idle);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), 1'b0);
    endtask

    initial begin
        logic [DW-1:0] word;

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        chk("rst_ready",   ready,   1'b1);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_done",    done,    1'b0);
        rst = 1'b1;
        @(negedge clk);

        // 8'hA5 MSB-first (LSB-first instance sees the same stimulus).
        line.delete();
        step(1'b1, 8'hA5, 1'b0);
        idle_steps(14);
        chk("loop_pre", (line[0] & ~line[1] & line[2] & line[3]), 1'b1);
        for (int i = 0; i < 8; i++) word[7-i] = line[4+i];
        chk("loop_word_eq_a5", (word == 8'hA5), 1'b1);

        // 8'h01 frame.
        step(1'b1, 8'h01, 1'b0);
        idle_steps(14);

        // Start pulsed with new data during payload bit 3 is ignored.
        step(1'b1, 8'h3C, 1'b0);
        idle_steps(7);
        step(1'b1, 8'hFF, 1'b0);
        idle_steps(10);

        // Start held high: back-to-back frames, 14-cycle period.
        for (int i = 0; i < 14; i++) step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 8'hFF, 1'b0);
        idle_steps(3);

        // Abort during payload bit 2.
        step(1'b1, 8'hA5, 1'b0);
        idle_steps(6);
        step(1'b0, 8'h00, 1'b1);
        idle_steps(3);

        // Abort together with start in IDLE: frame still starts.
        step(1'b1, 8'h5A, 1'b1);
        idle_steps(14);

        // Asynchronous reset mid-DATA.
        step(1'b1, 8'hC3, 1'b0);
        idle_steps(6);
        rst = 1'b0;
        #1;
        chk("arst_ser_out", ser_out, 1'b0);
        chk("arst_busy",    busy,    1'b0);
        chk("arst_done",    done,    1'b0);
        chk("arst_ready",   ready,   1'b1);
        q.delete();
        cur_idle = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h96, 1'b0);
        idle_steps(14);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), DW'($urandom), ($urandom_range(0, 31) == 0));
        end
        idle_steps(16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
